// File: rtl/spi_rr_scheduler_pkg.sv
// Shared types and constants for the SPI round-robin transaction scheduler.
package spi_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Width of a requester / slave index.
    localparam int ID_W = 2;

    // Counter width that can hold 0..timeout.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/spi_rr_scheduler_if.sv
// Requester and SPI-master facing signals of the scheduler, bundled as one interface.
interface spi_rr_scheduler_if
    import spi_sched_pkg::*;
#(
    parameter int BITS_SIZE = 8,
    parameter int NUM_REQ   = 4
);
    // Requester side
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BITS_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           grant;
    logic                         rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [BITS_SIZE-1:0]         rsp_data;
    logic                         rsp_timeout;
    logic                         busy;
    // SPI master side
    logic                         spi_tx_start;
    logic [ID_W-1:0]              spi_slave_sel;
    logic [BITS_SIZE-1:0]         spi_data_in;
    logic                         spi_rx_done;
    logic [BITS_SIZE-1:0]         spi_data_out;

    // The scheduler itself.
    modport slave (
        input  req, req_data, spi_rx_done, spi_data_out,
        output grant, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy,
               spi_tx_start, spi_slave_sel, spi_data_in
    );

    // The environment: requesters plus the SPI master.
    modport master (
        output req, req_data, spi_rx_done, spi_data_out,
        input  grant, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy,
               spi_tx_start, spi_slave_sel, spi_data_in
    );
endinterface

// File: rtl/spi_rr_scheduler_rr_arbiter4.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping 3 -> 0.
module rr_arbiter4
    import spi_sched_pkg::*;
(
    input  logic [3:0]      req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] id
);
    logic            found;
    logic [ID_W-1:0] idx;

    // Scan the four candidates in priority order starting from ptr.
    always_comb begin
        any   = |req;
        id    = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && req[idx]) begin
                id    = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_rr_scheduler.sv
// Round-robin scheduler: arbitrates four requesters, runs one SPI byte exchange at a time,
// and returns the received word (or a timeout indication) to the winner.
module spi_rr_scheduler
    import spi_sched_pkg::*;
#(
    parameter int BITS_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 1023
)(
    input  logic              clk,
    input  logic              reset_n,
    spi_rr_scheduler_if.slave bus
);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]        sel_q, sel_d;
    logic [BITS_SIZE-1:0]   data_in_q, data_in_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [BITS_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic                   rsp_to_q, rsp_to_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   tx_start_q, tx_start_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   busy_q, busy_d;

    logic                   arb_any;
    logic [ID_W-1:0]        arb_id;

    rr_arbiter4 u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .any (arb_any),
        .id  (arb_id)
    );

    // Next-state and registered-output computation; outputs are decided one cycle ahead.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        data_in_d   = data_in_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_to_d    = rsp_to_q;
        grant_d     = '0;
        tx_start_d  = 1'b0;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d    = START;
                    sel_d      = arb_id;
                    data_in_d  = bus.req_data[int'(arb_id)*BITS_SIZE +: BITS_SIZE];
                    grant_d    = NUM_REQ'(1) << arb_id;
                    tx_start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A completed receive wins over a simultaneous timeout.
                if (bus.spi_rx_done) begin
                    state_d     = RESP;
                    rsp_id_d    = sel_q;
                    rsp_data_d  = bus.spi_data_out;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_id_d    = sel_q;
                    rsp_data_d  = '0;
                    rsp_to_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                ptr_d   = rsp_id_q + ID_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            data_in_q   <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_to_q    <= 1'b0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            data_in_q   <= data_in_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_to_q    <= rsp_to_d;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_timeout   = rsp_to_q;
    assign bus.busy          = busy_q;
    assign bus.spi_tx_start  = tx_start_q;
    assign bus.spi_slave_sel = sel_q;
    assign bus.spi_data_in   = data_in_q;

endmodule

// File: tb/tb_spi_rr_scheduler.sv
// Directed bench for spi_rr_scheduler: one instance with the default timeout, one with TIMEOUT=16.
module tb_spi_rr_scheduler;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_rr_scheduler_if #(.BITS_SIZE(8), .NUM_REQ(4)) ba ();
    spi_rr_scheduler_if #(.BITS_SIZE(8), .NUM_REQ(4)) bb ();

    spi_rr_scheduler #(.BITS_SIZE(8), .NUM_REQ(4), .TIMEOUT(1023)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ba)
    );

    spi_rr_scheduler #(.BITS_SIZE(8), .NUM_REQ(4), .TIMEOUT(16)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_a(input string pfx);
        chk({pfx, " grant"},     32'(ba.grant),         32'h0);
        chk({pfx, " rsp_valid"}, 32'(ba.rsp_valid),     32'h0);
        chk({pfx, " rsp_id"},    32'(ba.rsp_id),        32'h0);
        chk({pfx, " rsp_data"},  32'(ba.rsp_data),      32'h0);
        chk({pfx, " rsp_to"},    32'(ba.rsp_timeout),   32'h0);
        chk({pfx, " busy"},      32'(ba.busy),          32'h0);
        chk({pfx, " tx_start"},  32'(ba.spi_tx_start),  32'h0);
        chk({pfx, " slave_sel"}, 32'(ba.spi_slave_sel), 32'h0);
        chk({pfx, " data_in"},   32'(ba.spi_data_in),   32'h0);
    endtask

    // Caller sets ba.req with the bench sitting in IDLE; this runs one full transaction on dut_a.
    task automatic txn_a(input int id, input logic [7:0] exp_din, input logic [7:0] ret,
                         input int wait_n, input logic [3:0] new_req);
        tick();
        chk("grant",     32'(ba.grant),         32'(4'b0001 << id));
        chk("tx_start",  32'(ba.spi_tx_start),  32'h1);
        chk("slave_sel", 32'(ba.spi_slave_sel), 32'(id));
        chk("data_in",   32'(ba.spi_data_in),   32'(exp_din));
        chk("busy_st",   32'(ba.busy),          32'h1);
        ba.req = new_req;
        tick();
        chk("grant_off", 32'(ba.grant),         32'h0);
        chk("tx_off",    32'(ba.spi_tx_start),  32'h0);
        chk("busy_wt",   32'(ba.busy),          32'h1);
        for (int i = 0; i < wait_n; i++) begin
            tick();
            chk("no_rsp_wt", 32'(ba.rsp_valid), 32'h0);
        end
        ba.spi_rx_done  = 1'b1;
        ba.spi_data_out = ret;
        tick();
        chk("rsp_valid", 32'(ba.rsp_valid),   32'h1);
        chk("rsp_id",    32'(ba.rsp_id),      32'(id));
        chk("rsp_data",  32'(ba.rsp_data),    32'(ret));
        chk("rsp_to",    32'(ba.rsp_timeout), 32'h0);
        chk("sel_held",  32'(ba.spi_slave_sel), 32'(id));
        ba.spi_rx_done  = 1'b0;
        ba.spi_data_out = 8'h00;
        tick();
        chk("rsp_drop",  32'(ba.rsp_valid), 32'h0);
        chk("busy_idle", 32'(ba.busy),      32'h0);
        chk("data_hold", 32'(ba.rsp_data),  32'(ret));
    endtask

    initial begin
        reset_n         = 1'b0;
        ba.req          = '0;
        ba.req_data     = '0;
        ba.spi_rx_done  = 1'b0;
        ba.spi_data_out = '0;
        bb.req          = '0;
        bb.req_data     = '0;
        bb.spi_rx_done  = 1'b0;
        bb.spi_data_out = '0;
        tick();
        tick();
        zero_a("rst");
        chk("rst_b busy",  32'(bb.busy),  32'h0);
        chk("rst_b grant", 32'(bb.grant), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("idle busy", 32'(ba.busy), 32'h0);

        // All four requesting continuously: order 0,1,2,3,0.
        ba.req      = 4'b1111;
        ba.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        txn_a(0, 8'h11, 8'h10, 2, 4'b1111);
        txn_a(1, 8'h22, 8'h11, 2, 4'b1111);
        txn_a(2, 8'h33, 8'h12, 2, 4'b1111);
        txn_a(3, 8'h44, 8'h13, 2, 4'b1111);
        txn_a(0, 8'h11, 8'h10, 2, 4'b0000);

        // Single requester 2, response 20 cycles after start; leaves ptr at 3.
        ba.req      = 4'b0100;
        ba.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        txn_a(2, 8'hA5, 8'h3C, 18, 4'b0000);
        tick();
        chk("hold rsp_id",   32'(ba.rsp_id),   32'h2);
        chk("hold rsp_data", 32'(ba.rsp_data), 32'h3C);

        // Stray rx_done while idle is ignored.
        ba.spi_rx_done  = 1'b1;
        ba.spi_data_out = 8'hFF;
        tick();
        chk("stray busy",  32'(ba.busy),      32'h0);
        chk("stray valid", 32'(ba.rsp_valid), 32'h0);
        ba.spi_rx_done  = 1'b0;
        ba.spi_data_out = 8'h00;
        tick();
        chk("stray data", 32'(ba.rsp_data), 32'h3C);

        // ptr=3: requests 0 and 3 -> 3 first, then 0.
        ba.req      = 4'b1001;
        ba.req_data = {8'hC3, 8'h00, 8'h00, 8'h0F};
        txn_a(3, 8'hC3, 8'h5A, 1, 4'b0001);
        txn_a(0, 8'h0F, 8'hA6, 0, 4'b0000);

        // Reset during WAIT, then a late rx_done: nothing is reported.
        ba.req      = 4'b0010;
        ba.req_data = {8'h00, 8'h00, 8'h77, 8'h00};
        tick();
        chk("r6 grant", 32'(ba.grant), 32'b0010);
        ba.req = 4'b0000;
        tick();
        tick();
        tick();
        chk("r6 busy", 32'(ba.busy), 32'h1);
        reset_n = 1'b0;
        tick();
        zero_a("midrst");
        reset_n         = 1'b1;
        ba.spi_rx_done  = 1'b1;
        ba.spi_data_out = 8'hEE;
        tick();
        chk("late valid", 32'(ba.rsp_valid), 32'h0);
        chk("late busy",  32'(ba.busy),      32'h0);
        ba.spi_rx_done  = 1'b0;
        ba.spi_data_out = 8'h00;
        tick();
        chk("late valid2", 32'(ba.rsp_valid), 32'h0);
        chk("late data",   32'(ba.rsp_data),  32'h0);
        ba.req      = 4'b0001;
        ba.req_data = {8'h00, 8'h00, 8'h00, 8'h0F};
        txn_a(0, 8'h0F, 8'h99, 2, 4'b0000);

        // TIMEOUT=16 instance: no rx_done -> timeout response 16 cycles after entering WAIT.
        bb.req      = 4'b0001;
        bb.req_data = {8'h00, 8'h00, 8'h00, 8'h55};
        tick();
        chk("b grant", 32'(bb.grant), 32'b0001);
        bb.req = 4'b0000;
        tick();
        chk("b busy_wt", 32'(bb.busy), 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("b no_rsp", 32'(bb.rsp_valid), 32'h0);
        end
        tick();
        chk("b to valid", 32'(bb.rsp_valid),   32'h1);
        chk("b to flag",  32'(bb.rsp_timeout), 32'h1);
        chk("b to data",  32'(bb.rsp_data),    32'h0);
        chk("b to id",    32'(bb.rsp_id),      32'h0);
        tick();
        chk("b to busy",  32'(bb.busy),      32'h0);
        chk("b to drop",  32'(bb.rsp_valid), 32'h0);

        // rx_done on the timeout edge wins.
        bb.req      = 4'b0010;
        bb.req_data = {8'h00, 8'h00, 8'h66, 8'h00};
        tick();
        chk("b2 grant", 32'(bb.grant), 32'b0010);
        bb.req = 4'b0000;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("b2 no_rsp", 32'(bb.rsp_valid), 32'h0);
        end
        bb.spi_rx_done  = 1'b1;
        bb.spi_data_out = 8'hB7;
        tick();
        chk("b2 valid", 32'(bb.rsp_valid),   32'h1);
        chk("b2 flag",  32'(bb.rsp_timeout), 32'h0);
        chk("b2 data",  32'(bb.rsp_data),    32'hB7);
        chk("b2 id",    32'(bb.rsp_id),      32'h1);
        bb.spi_rx_done  = 1'b0;
        bb.spi_data_out = 8'h00;
        tick();
        chk("b2 busy", 32'(bb.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rr_scheduler.md
Name: spi_rr_scheduler

Overview:
- Transaction scheduler in front of the 4-slave SPI subsystem (one master, slaves 0..3).
- Four requesters each want one full-duplex byte exchange with their own slave. The block arbitrates round-robin, selects the slave, and loads and starts the master.
- It waits for the master's receive-done (with a timeout), then returns the received word to the winning requester.
- Exactly one transaction is in flight at a time.

Parameters:
- BITS_SIZE, 8, word width; matches the SPI master/slave bits_size.
- NUM_REQ, 4, requester/slave count; fixed at 4 in this revision.
- TIMEOUT, 1023, maximum clk cycles spent in WAIT before the transaction is aborted; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  4  per-requester request level; req[i] targets slave i.
- req_data  in  4*BITS_SIZE  transmit words; slice i is [i*BITS_SIZE +: BITS_SIZE].
- grant  out  4  one-hot, one-cycle pulse: the request was accepted and req_data was latched.
- rsp_valid  out  1  one-cycle pulse: the response is available.
- rsp_id  out  2  index of the requester that owns the response.
- rsp_data  out  BITS_SIZE  word received from the slave.
- rsp_timeout  out  1  qualifies rsp_valid: the transaction timed out.
- busy  out  1  high in every state except IDLE.
- spi_tx_start  out  1  connects to master tx_start; one-cycle pulse.
- spi_slave_sel  out  2  slave index, drives the master's ss decode; held for the whole transaction.
- spi_data_in  out  BITS_SIZE  connects to master_data_in; held for the whole transaction.
- spi_rx_done  in  1  connects to master_rx_done.
- spi_data_out  in  BITS_SIZE  connects to master_data_out.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State goes to IDLE and the round-robin pointer ptr goes to 0.
  - The timeout counter is cleared.
  - All outputs become 0, spi_slave_sel=0 and spi_data_in=0.
  - This applies mid-transaction too: the in-flight transfer is abandoned and no rsp_valid is issued.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req != 0 at an edge, choose the first set bit searching from ptr upward, wrapping 3 to 0.
  - Latch id into spi_slave_sel/rsp_id and req_data[id] into spi_data_in, then go to START.
  - If req == 0, stay in IDLE.
- START:
  - Lasts exactly one cycle with grant[id]=1 and spi_tx_start=1; the next state is WAIT.
  - Clear the timeout counter.
- WAIT:
  - If spi_rx_done=1 at an edge: capture spi_data_out into rsp_data, set rsp_timeout=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 at an edge, go to RESP with rsp_timeout=1 and rsp_data=0.
  - rx_done has priority if it coincides with the timeout edge.
- RESP:
  - Lasts exactly one cycle with rsp_valid=1; rsp_id, rsp_data and rsp_timeout are valid.
  - ptr <= (rsp_id+1) mod 4, then go to IDLE.
- Latency:
  - req is sampled in IDLE at edge k; grant and spi_tx_start are high in cycle k+1.
  - rsp_valid is high in the cycle after the edge that sampled rx_done.
  - The minimum gap between the end of RESP and the next grant is 1 cycle, spent in IDLE.
- Requester rules:
  - A requester must hold req until its grant. It may deassert or reissue after grant.
  - A req that drops before IDLE samples it is simply not served.
  - Changing req or req_data after latch does not affect the in-flight transaction.
- spi_rx_done outside WAIT is ignored.
- rsp_data, rsp_id and rsp_timeout hold their values after RESP until the next RESP.
- Fairness: with all 4 requesting continuously, the grant order is 0,1,2,3,0,...

Decomposition:
- Package spi_sched_pkg:
  - state enum {IDLE, START, WAIT, RESP};
  - ID_W=2;
  - localparam for counter width, clog2(TIMEOUT+1).
- Sub-module rr_arbiter4: combinational rotating-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, id[1:0].
  - The top instantiates it once; all registers stay in the top.

Test Plan:
- Reset then req=4'b0100, req_data slice2=8'hA5, slave returns 8'h3C with rx_done 20 cycles after start → grant=4'b0100 one cycle, spi_slave_sel=2, spi_data_in=8'hA5, tx_start one pulse, rsp_valid with rsp_id=2, rsp_data=8'h3C, rsp_timeout=0.
- req=4'b1111 held continuously, each slave returns 8'h10+id → grants in order 0,1,2,3,0 with exactly one rsp_valid per grant and matching data.
- ptr=3 after serving id 2; next req=4'b1001 → id 3 served first, then id 0.
- TIMEOUT=16, rx_done never asserted → rsp_valid with rsp_timeout=1 and rsp_data=0 exactly 16 cycles after entering WAIT; busy then drops.
- rx_done coincident with the timeout edge → rsp_timeout=0 and the captured data is returned.
- reset_n=0 for one cycle during WAIT, followed by a late rx_done → no rsp_valid, all outputs 0, busy=0, and the next req=4'b0001 is granted to id 0.
